seq_match_monitor: RTL and testbench

//  Downstream consumer of the 101 sequence detector's registered 1-cycle match pulse.

---
 rtl/seq_match_monitor.sv | 108 ++++++++++
 tb/tb_seq_match_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_match_monitor.sv
// Match-pulse monitor: counts detector matches in total and per fixed window,
// and latches a sticky alarm when a completed window reaches THRESH matches.
module seq_match_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             match_in,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] last_win,
  output logic             win_done,
  output logic             alarm,
  output logic             busy
);

  localparam int TW = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [TW-1:0]    T_LAST = TW'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] C_MAX  = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ALARM = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer;
  logic             counting;
  logic             win_end;
  logic             hit;
  logic [CNT_W-1:0] win_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x,
                                                input logic inc);
    if (inc && (x != C_MAX)) return x + CNT_W'(1);
    return x;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (en) state_nxt = RUN;
        RUN:     if (!en) state_nxt = IDLE;
                 else if (win_end && hit) state_nxt = ALARM;
        ALARM:   state_nxt = ALARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Window bookkeeping decoded from the current state; the final-cycle match
  // is folded into win_next so it counts toward the ending window.
  always_comb begin
    counting = en && (state != IDLE);
    win_end  = counting && (timer == T_LAST);
    win_next = sat_inc(win_cnt, match_in);
    hit      = (win_next >= THR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer     <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      last_win  <= '0;
      win_done  <= 1'b0;
      alarm     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      win_done <= 1'b0;
      busy     <= (state_nxt != IDLE);
      if (clr) begin
        timer     <= '0;
        match_cnt <= '0;
        win_cnt   <= '0;
        last_win  <= '0;
        alarm     <= 1'b0;
      end else if (counting) begin
        match_cnt <= sat_inc(match_cnt, match_in);
        if (win_end) begin
          timer    <= '0;
          win_cnt  <= '0;
          last_win <= win_next;
          win_done <= 1'b1;
          if (hit) alarm <= 1'b1;
        end else begin
          timer   <= timer + TW'(1);
          win_cnt <= win_next;
        end
      end else if (state != ALARM) begin
        // Leaving RUN discards the partial window; ALARM with en low freezes.
        timer   <= '0;
        win_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_match_monitor.sv
// Bench for seq_match_monitor: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a behavioural model.
module tb_seq_match_monitor;
  localparam int CNT_W   = 8;
  localparam int WIN_LEN = 16;
  localparam int THRESH  = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, clr = 1'b0, match_in = 1'b0;
  logic [CNT_W-1:0] match_cnt, win_cnt, last_win;
  logic win_done, alarm, busy;
  logic [3:0] b_match_cnt, b_win_cnt, b_last_win;
  logic b_win_done, b_alarm, b_busy;

  int total_n = 0;
  int bad_n   = 0;

  always #5 clk = ~clk;

  seq_match_monitor #(.CNT_W(CNT_W), .WIN_LEN(WIN_LEN), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .match_in(match_in),
    .match_cnt(match_cnt), .win_cnt(win_cnt), .last_win(last_win),
    .win_done(win_done), .alarm(alarm), .busy(busy)
  );

  // Narrow counters with a long window, to see win_cnt saturate.
  seq_match_monitor #(.CNT_W(4), .WIN_LEN(300), .THRESH(4)) u_big (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .match_in(match_in),
    .match_cnt(b_match_cnt), .win_cnt(b_win_cnt), .last_win(b_last_win),
    .win_done(b_win_done), .alarm(b_alarm), .busy(b_busy)
  );

  // Behavioural model: unbounded integer tallies, clamped only when compared.
  int m_mode;  // 0 idle, 1 running, 2 alarmed
  int m_pos, m_win, m_tot, m_last;
  bit m_done, m_alarm;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_pos = 0; m_win = 0; m_tot = 0; m_last = 0;
      m_done = 0; m_alarm = 0;
    end else begin
      m_done = 0;
      if (clr) begin
        m_mode = 0; m_pos = 0; m_win = 0; m_tot = 0; m_last = 0; m_alarm = 0;
      end else if (m_mode == 0) begin
        if (en) m_mode = 1;
      end else if (!en) begin
        if (m_mode == 1) begin
          m_mode = 0; m_pos = 0; m_win = 0;
        end
      end else begin
        if (match_in) begin
          m_win++;
          m_tot++;
        end
        if (m_pos == WIN_LEN - 1) begin
          m_last = m_win;
          m_done = 1;
          if (m_win >= THRESH) begin
            m_alarm = 1;
            m_mode  = 2;
          end
          m_pos = 0;
          m_win = 0;
        end else begin
          m_pos++;
        end
      end
    end
  end

  function automatic int sat(int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total_n++;
    if (act != exp) begin
      bad_n++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("match_cnt", int'(match_cnt), sat(m_tot));
    chk("win_cnt", int'(win_cnt), sat(m_win));
    chk("last_win", int'(last_win), sat(m_last));
    chk("win_done", int'(win_done), int'(m_done));
    chk("alarm", int'(alarm), int'(m_alarm));
    chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
  end

  // Drive one cycle's inputs; returns just after the edge that consumed them.
  task automatic cyc(input bit e, input bit c, input bit m);
    en = e; clr = c; match_in = m;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_match_cnt", int'(match_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_alarm", int'(alarm), 0);
    rst = 1'b1;

    // Window with 3 matches
    cyc(1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, (i == 2 || i == 5 || i == 9));
    chk("t1_win_done", int'(win_done), 1);
    chk("t1_last_win", int'(last_win), 3);
    chk("t1_alarm", int'(alarm), 0);
    chk("t1_match_cnt", int'(match_cnt), 3);
    chk("t1_model_last", m_last, 3);

    // 4 matches, the last on the final window cycle
    for (int i = 0; i < 16; i++) cyc(1, 0, (i == 0 || i == 3 || i == 7 || i == 15));
    chk("t2_last_win", int'(last_win), 4);
    chk("t2_alarm", int'(alarm), 1);
    chk("t2_win_done", int'(win_done), 1);
    chk("t2_busy", int'(busy), 1);
    chk("t2_model_mode", m_mode, 2);

    // Quiet windows in ALARM with an en-low freeze in between, then clear
    for (int i = 0; i < 16; i++) cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0);
    chk("t3_alarm", int'(alarm), 1);
    chk("t3_win_done", int'(win_done), 1);
    chk("t3_last_win", int'(last_win), 0);
    cyc(1, 1, 0);
    chk("t3_clr_match_cnt", int'(match_cnt), 0);
    chk("t3_clr_last_win", int'(last_win), 0);
    chk("t3_clr_alarm", int'(alarm), 0);
    chk("t3_clr_busy", int'(busy), 0);

    // Drop en mid-window after 5 matches
    cyc(1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, (i % 2 == 0));
    chk("t4_win_cnt_pre", int'(win_cnt), 5);
    cyc(0, 0, 0);
    chk("t4_win_cnt", int'(win_cnt), 0);
    chk("t4_win_done", int'(win_done), 0);
    chk("t4_alarm", int'(alarm), 0);
    chk("t4_match_cnt", int'(match_cnt), 5);
    chk("t4_busy", int'(busy), 0);

    // Saturation
    cyc(1, 1, 0);
    cyc(1, 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, 0, 1);
    chk("t5_big_win_cnt", int'(b_win_cnt), 15);
    chk("t5_big_match_cnt", int'(b_match_cnt), 15);
    chk("t5_big_alarm", int'(b_alarm), 0);
    chk("t5_big_win_done", int'(b_win_done), 0);
    chk("t5_big_last_win", int'(b_last_win), 0);
    chk("t5_big_busy", int'(b_busy), 1);
    chk("t5_match_cnt_20", int'(match_cnt), 20);
    for (int i = 0; i < 300; i++) cyc(1, 0, 1);
    chk("t5_match_cnt_sat", int'(match_cnt), 255);
    chk("t5_model_tot_sat", sat(m_tot), 255);

    // clr wins over a same-cycle match; IDLE ignores the entry-cycle match
    cyc(1, 1, 1);
    chk("t6_match_cnt", int'(match_cnt), 0);
    chk("t6_busy", int'(busy), 0);
    cyc(1, 0, 1);
    chk("t6_entry_match_cnt", int'(match_cnt), 0);
    chk("t6_entry_busy", int'(busy), 1);

    // Asynchronous reset mid-window
    for (int i = 0; i < 5; i++) cyc(1, 0, 1);
    chk("t6b_pre_win_cnt", int'(win_cnt), 5);
    rst = 1'b0;
    #1;
    chk("t6b_match_cnt", int'(match_cnt), 0);
    chk("t6b_win_cnt", int'(win_cnt), 0);
    chk("t6b_busy", int'(busy), 0);
    chk("t6b_win_done", int'(win_done), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Random traffic
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 9) < 3);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
